// File: rtl/bip_control_seq_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states and
// accumulator source select encodings.
package bip_control_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int unsigned OP_HLT  = 0;
  localparam int unsigned OP_STO  = 1;
  localparam int unsigned OP_LD   = 2;
  localparam int unsigned OP_LDI  = 3;
  localparam int unsigned OP_ADD  = 4;
  localparam int unsigned OP_ADDI = 5;
  localparam int unsigned OP_SUB  = 6;
  localparam int unsigned OP_SUBI = 7;
  localparam int unsigned OP_BEQ  = 8;
  localparam int unsigned OP_BNE  = 9;
  localparam int unsigned OP_JMP  = 10;

  localparam logic [1:0] SELA_RAM = 2'd0;
  localparam logic [1:0] SELA_OPD = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: datapath strobes, branch decision and halt
// detect. Outputs are ungated; the caller qualifies them with its EXEC state.
module bip_decoder
  import bip_control_seq_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic             acc_zero,
  output logic [1:0]       sel_a,
  output logic             sel_b,
  output logic             op,
  output logic             wr_acc,
  output logic             wr_ram,
  output logic             rd_ram,
  output logic             branch_taken,
  output logic             is_halt
);

  always_comb begin
    sel_a        = SELA_RAM;
    sel_b        = 1'b0;
    op           = 1'b0;
    wr_acc       = 1'b0;
    wr_ram       = 1'b0;
    rd_ram       = 1'b0;
    branch_taken = 1'b0;
    is_halt      = 1'b0;
    case (opcode)
      OPC_W'(OP_HLT):  is_halt = 1'b1;
      OPC_W'(OP_STO):  wr_ram = 1'b1;
      OPC_W'(OP_LD): begin
        rd_ram = 1'b1;
        wr_acc = 1'b1;
        sel_a  = SELA_RAM;
      end
      OPC_W'(OP_LDI): begin
        wr_acc = 1'b1;
        sel_a  = SELA_OPD;
      end
      OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
        rd_ram = 1'b1;
        wr_acc = 1'b1;
        sel_a  = SELA_ALU;
        sel_b  = 1'b0;
        op     = (opcode == OPC_W'(OP_SUB));
      end
      OPC_W'(OP_ADDI), OPC_W'(OP_SUBI): begin
        wr_acc = 1'b1;
        sel_a  = SELA_ALU;
        sel_b  = 1'b1;
        op     = (opcode == OPC_W'(OP_SUBI));
      end
      OPC_W'(OP_BEQ):  branch_taken = acc_zero;
      OPC_W'(OP_BNE):  branch_taken = ~acc_zero;
      OPC_W'(OP_JMP):  branch_taken = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control_seq.sv
// BIP control unit: PC ownership, handshaked fetch, one-cycle execute and a
// terminal HALT state that only reset leaves.
module bip_control_seq
  import bip_control_seq_pkg::*;
#(
  parameter int PC_W     = 11,
  parameter int OPC_W    = 5,
  parameter int OPD_W    = 11,
  parameter int RESET_PC = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [OPC_W+OPD_W-1:0] Instruction,
  input  logic                   instr_valid,
  input  logic                   acc_zero,
  output logic                   fetch_req,
  output logic [PC_W-1:0]        PC,
  output logic [OPC_W-1:0]       Opcode,
  output logic [OPD_W-1:0]       Operand,
  output logic [1:0]             SelA,
  output logic                   SelB,
  output logic                   Op,
  output logic                   WrAcc,
  output logic                   WrRam,
  output logic                   RdRam,
  output logic                   halted
);

  state_e     state;
  logic       in_exec;
  logic [1:0] dec_sel_a;
  logic       dec_sel_b, dec_op, dec_wr_acc, dec_wr_ram, dec_rd_ram;
  logic       dec_taken, dec_halt;

  bip_decoder #(.OPC_W(OPC_W)) u_dec (
    .opcode       (Opcode),
    .acc_zero     (acc_zero),
    .sel_a        (dec_sel_a),
    .sel_b        (dec_sel_b),
    .op           (dec_op),
    .wr_acc       (dec_wr_acc),
    .wr_ram       (dec_wr_ram),
    .rd_ram       (dec_rd_ram),
    .branch_taken (dec_taken),
    .is_halt      (dec_halt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_FETCH;
      PC      <= PC_W'(RESET_PC);
      Opcode  <= '0;
      Operand <= '0;
    end else begin
      case (state)
        // fetch: wait for the program memory handshake, PC holds
        ST_FETCH: begin
          if (instr_valid) begin
            Opcode  <= Instruction[OPC_W+OPD_W-1 -: OPC_W];
            Operand <= Instruction[OPD_W-1:0];
            state   <= ST_EXEC;
          end
        end
        // execute: strobes live this cycle, PC resolves at its end
        ST_EXEC: begin
          if (dec_halt) begin
            state <= ST_HALT;
          end else begin
            state <= ST_FETCH;
            PC    <= dec_taken ? Operand[PC_W-1:0] : PC + PC_W'(1);
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Gating by the state register makes the strobes fall with an async reset.
  assign in_exec   = (state == ST_EXEC);
  assign fetch_req = (state == ST_FETCH);
  assign halted    = (state == ST_HALT);
  assign SelA      = in_exec ? dec_sel_a : 2'd0;
  assign SelB      = in_exec & dec_sel_b;
  assign Op        = in_exec & dec_op;
  assign WrAcc     = in_exec & dec_wr_acc;
  assign WrRam     = in_exec & dec_wr_ram;
  assign RdRam     = in_exec & dec_rd_ram;

endmodule

// File: tb/tb_bip_control_seq.sv
// Directed plus randomized bench for bip_control_seq against an opcode-table
// reference model; a second instance covers the narrow-PC configuration.
module tb_bip_control_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr_a = '0;
  logic        valid_a = 1'b0;
  logic        az_a = 1'b0;
  logic        fetch_a, halted_a, selb_a, op_a, wracc_a, wrram_a, rdram_a;
  logic [10:0] pc_a;
  logic [4:0]  opc_a;
  logic [10:0] opd_a;
  logic [1:0]  sela_a;

  logic [12:0] instr_b = '0;
  logic        valid_b = 1'b0;
  logic        az_b = 1'b0;
  logic        fetch_b, halted_b, selb_b, op_b, wracc_b, wrram_b, rdram_b;
  logic [7:0]  pc_b;
  logic [4:0]  opc_b;
  logic [7:0]  opd_b;
  logic [1:0]  sela_b;

  int checks = 0;
  int failures = 0;
  int exp_pc = 0;

  always #5 clock = ~clock;

  bip_control_seq dut_a (
    .clock(clock), .reset(reset), .Instruction(instr_a), .instr_valid(valid_a),
    .acc_zero(az_a), .fetch_req(fetch_a), .PC(pc_a), .Opcode(opc_a),
    .Operand(opd_a), .SelA(sela_a), .SelB(selb_a), .Op(op_a), .WrAcc(wracc_a),
    .WrRam(wrram_a), .RdRam(rdram_a), .halted(halted_a)
  );

  bip_control_seq #(.PC_W(8), .OPC_W(5), .OPD_W(8), .RESET_PC(16)) dut_b (
    .clock(clock), .reset(reset), .Instruction(instr_b), .instr_valid(valid_b),
    .acc_zero(az_b), .fetch_req(fetch_b), .PC(pc_b), .Opcode(opc_b),
    .Operand(opd_b), .SelA(sela_b), .SelB(selb_b), .Op(op_b), .WrAcc(wracc_b),
    .WrRam(wrram_b), .RdRam(rdram_b), .halted(halted_b)
  );

  wire [6:0] ctl_a = {sela_a, selb_a, op_a, wracc_a, wrram_a, rdram_a};
  wire [6:0] ctl_b = {sela_b, selb_b, op_b, wracc_b, wrram_b, rdram_b};

  // Reference table: {SelA, SelB, Op, WrAcc, WrRam, RdRam} per opcode in EXEC.
  function automatic logic [6:0] model_ctl(input int opc);
    logic [1:0] sa = 0;
    logic sb = 0, o = 0, wa = 0, wr = 0, rd = 0;
    case (opc)
      1: wr = 1;
      2: begin rd = 1; wa = 1; end
      3: begin wa = 1; sa = 1; end
      4: begin rd = 1; wa = 1; sa = 2; end
      5: begin wa = 1; sa = 2; sb = 1; end
      6: begin rd = 1; wa = 1; sa = 2; o = 1; end
      7: begin wa = 1; sa = 2; sb = 1; o = 1; end
      default: ;
    endcase
    return {sa, sb, o, wa, wr, rd};
  endfunction

  function automatic bit model_taken(input int opc, input bit az);
    return (opc == 8 && az) || (opc == 9 && !az) || (opc == 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One instruction through dut_a with optional wait states before it.
  task automatic exec_a(input logic [15:0] ins, input bit az, input int waits);
    int opc = int'(ins[15:11]);
    int opd = int'(ins[10:0]);
    for (int i = 0; i < waits; i++) begin
      instr_a = 16'($urandom);
      valid_a = 1'b0;
      step();
      chk("wait_pc", 32'(pc_a), 32'(exp_pc));
      chk("wait_ctl", 32'(ctl_a), 32'd0);
      chk("wait_fetch", 32'(fetch_a), 32'd1);
    end
    instr_a = ins;
    valid_a = 1'b1;
    az_a = az;
    step();
    instr_a = ~ins;
    chk("exec_ctl", 32'(ctl_a), 32'(model_ctl(opc)));
    chk("exec_fetch", 32'(fetch_a), 32'd0);
    chk("exec_latch", {16'd0, opc_a, opd_a}, {16'd0, ins});
    chk("exec_pc_hold", 32'(pc_a), 32'(exp_pc));
    step();
    valid_a = 1'b0;
    if (opc != 0)
      exp_pc = model_taken(opc, az) ? opd : (exp_pc + 1) % 2048;
    chk("post_pc", 32'(pc_a), 32'(exp_pc));
    chk("post_halted", 32'(halted_a), 32'(opc == 0));
    chk("post_ctl", 32'(ctl_a), 32'd0);
    chk("post_latch", {16'd0, opc_a, opd_a}, {16'd0, ins});
  endtask

  initial begin
    // Reset and first fetch
    reset = 1'b0;
    repeat (2) step();
    chk("rst_pc_a", 32'(pc_a), 32'd0);
    chk("rst_pc_b", 32'(pc_b), 32'h10);
    chk("rst_ctl", 32'(ctl_a), 32'd0);
    reset = 1'b1;
    step();
    chk("rel_fetch", 32'(fetch_a), 32'd1);
    chk("rel_halted", 32'(halted_a), 32'd0);
    chk("rel_latch", {16'd0, opc_a, opd_a}, 32'd0);
    exec_a(16'h1805, 1'b0, 0);

    // Wait states, then walk PC to 3 for the branch cases
    exec_a({5'd2, 11'h044}, 1'b0, 4);
    exec_a({5'd1, 11'h055}, 1'b0, 0);
    exec_a({5'd8, 11'h020}, 1'b1, 1);
    exec_a({5'd10, 11'h003}, 1'b0, 0);
    exec_a({5'd9, 11'h020}, 1'b1, 0);
    exec_a({5'd10, 11'h7FF}, 1'b0, 2);
    exec_a({5'd5, 11'h001}, 1'b0, 0);

    // Randomized program, HLT excluded
    for (int n = 0; n < 60; n++) begin
      logic [4:0] ro = 5'($urandom_range(1, 31));
      exec_a({ro, 11'($urandom)}, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Halt at PC=6
    exec_a({5'd10, 11'h006}, 1'b0, 0);
    exec_a({5'd0, 11'h123}, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      instr_a = {5'd10, 11'($urandom)};
      valid_a = 1'b1;
      step();
      chk("halt_pc", 32'(pc_a), 32'd6);
      chk("halt_state", {30'd0, halted_a, fetch_a}, 32'b10);
      chk("halt_ctl", 32'(ctl_a), 32'd0);
    end
    valid_a = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    exp_pc = 0;
    chk("unhalt_pc", 32'(pc_a), 32'd0);
    chk("unhalt_state", {30'd0, halted_a, fetch_a}, 32'b01);

    // Reset in the middle of a STO execute
    instr_a = {5'd1, 11'h0AA};
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    chk("mid_wrram_on", 32'(wrram_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_wrram_drop", 32'(wrram_a), 32'd0);
    chk("mid_pc", 32'(pc_a), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("mid_pc_after", 32'(pc_a), 32'd0);
    chk("mid_fetch", 32'(fetch_a), 32'd1);

    // Narrow configuration: JMP 0xFF then a NOP wraps to 0
    chk("b_start_pc", 32'(pc_b), 32'h10);
    instr_b = {5'd10, 8'hFF};
    valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    chk("b_jmp_ctl", 32'(ctl_b), 32'd0);
    step();
    chk("b_jmp_pc", 32'(pc_b), 32'hFF);
    instr_b = {5'd31, 8'h12};
    valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    chk("b_nop_ctl", 32'(ctl_b), 32'd0);
    step();
    chk("b_wrap_pc", 32'(pc_b), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
